// File: rtl/uart_tx_fifo_if.sv
// Byte handshake from the core's character-output port into the UART transmitter.
interface uart_tx_fifo_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 serial transmitter fed by a small byte FIFO; frames are sent back to back while data is queued.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    uart_tx_fifo_if.slave               in_if,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    head;
    logic          push;
    logic          pop;
    logic          timer_done;

    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign in_if.in_ready = (count_q != COUNT_FULL);
    assign push           = in_if.in_valid && in_if.in_ready;
    assign head           = mem_q[rd_ptr_q];
    assign timer_done     = (timer_q == TIMER_LAST);

    assign tx         = tx_q;
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign fifo_count = count_q;

    // FIFO pointer and occupancy update.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    // Frame sequencing; tx_d is the line level for the cycle after the edge.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = head;
                    timer_d = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (timer_done) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA: begin
                if (timer_done) begin
                    timer_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STOP: begin
                if (timer_done) begin
                    timer_d = '0;
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_if.in_data;
    end

    // State, counters and line register; reset discards any frame and queued bytes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed waveform checks plus a randomized byte stream decoded off the tx line.
module tb_uart_tx_fifo;
    localparam int unsigned CPB   = 4;
    localparam int unsigned CPB2  = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tx4, busy4, tx2, busy2;
    logic [CW-1:0] cnt4, cnt2;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    uart_tx_fifo_if bus4 ();
    uart_tx_fifo_if bus2 ();

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_if(bus4.slave),
        .tx(tx4), .busy(busy4), .fifo_count(cnt4)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(CPB2), .FIFO_DEPTH(DEPTH)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_if(bus2.slave),
        .tx(tx2), .busy(busy2), .fifo_count(cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line level of bit slot j (0 = start, 1..8 = data LSB first, 9 = stop) of an 8N1 frame.
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j >= 9) return 1'b1;
        return b[j-1];
    endfunction

    // Offer one byte on bus4 until accepted; accepted bytes feed the expected queue.
    task automatic push_byte(input logic [7:0] b, input int max_wait);
        logic acc;
        bus4.in_data  = b;
        bus4.in_valid = 1'b1;
        for (int w = 0; w < max_wait; w++) begin
            acc = bus4.in_valid && bus4.in_ready;
            tick();
            if (acc) begin
                exp_q.push_back(b);
                bus4.in_valid = 1'b0;
                return;
            end
        end
        bus4.in_valid = 1'b0;
        check("push_timeout", 32'(bus4.in_ready), 32'd1);
    endtask

    // Receive one frame from tx4 by mid-bit sampling and compare with the oldest accepted byte.
    task automatic rx_byte(input int max_wait);
        logic [7:0] b;
        int n;
        n = 0;
        while (tx4 !== 1'b0 && n < max_wait) begin
            tick();
            n++;
        end
        if (tx4 !== 1'b0) begin
            check("rx_timeout", 32'(tx4), 32'd0);
            return;
        end
        repeat (CPB / 2) tick();
        check("rx_start", 32'(tx4), 32'd0);
        for (int j = 0; j < 8; j++) begin
            repeat (CPB) tick();
            b[j] = tx4;
        end
        repeat (CPB) tick();
        check("rx_stop", 32'(tx4), 32'd1);
        if (exp_q.size() == 0) begin
            check("rx_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
            check("rx_byte", 32'(b), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin
        int  idx;
        logic acc;
        int  fill_cnt [5] = '{1, 1, 2, 3, 4};
        logic [7:0] r;

        rst_n = 1'b0;
        bus4.in_valid = 1'b0;
        bus4.in_data  = 8'h00;
        bus2.in_valid = 1'b0;
        bus2.in_data  = 8'h00;

        // Reset values
        tick();
        tick();
        check("rst_tx", 32'(tx4), 32'd1);
        check("rst_ready", 32'(bus4.in_ready), 32'd1);
        check("rst_busy", 32'(busy4), 32'd0);
        check("rst_count", 32'(cnt4), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rel_tx", 32'(tx4), 32'd1);
        check("rel_ready", 32'(bus4.in_ready), 32'd1);
        check("rel_busy", 32'(busy4), 32'd0);
        check("rel_count", 32'(cnt4), 32'd0);
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_tx", 32'(tx4), 32'd1);
        end

        // Single byte 0xA5: cycle-exact frame starting after edge 1
        bus4.in_data  = 8'hA5;
        bus4.in_valid = 1'b1;
        tick();
        bus4.in_valid = 1'b0;
        check("a5_count", 32'(cnt4), 32'd1);
        check("a5_tx_pre", 32'(tx4), 32'd1);
        check("a5_busy_pre", 32'(busy4), 32'd1);
        for (int i = 0; i < 40; i++) begin
            tick();
            check("a5_tx", 32'(tx4), 32'(frame_bit(8'hA5, i / 4)));
            check("a5_busy", 32'(busy4), 32'd1);
        end
        tick();
        check("a5_busy_end", 32'(busy4), 32'd0);
        check("a5_tx_end", 32'(tx4), 32'd1);
        check("a5_count_end", 32'(cnt4), 32'd0);

        // Fill and back-pressure: 0x10..0x15 offered back to back
        idx = 0;
        bus4.in_data  = 8'h10;
        bus4.in_valid = 1'b1;
        for (int e = 0; e <= 240; e++) begin
            acc = bus4.in_valid && bus4.in_ready;
            tick();
            if (acc) begin
                if (idx < 5) check("fill_count", 32'(cnt4), 32'(fill_cnt[idx]));
                if (idx == 4) check("fill_ready", 32'(bus4.in_ready), 32'd0);
                if (idx == 5) check("last_accept_edge", 32'(e), 32'd42);
                idx++;
                if (idx < 6) bus4.in_data = 8'(8'h10 + idx);
                else         bus4.in_valid = 1'b0;
            end
            if (e >= 1) check("b2b_tx", 32'(tx4), 32'(frame_bit(8'(8'h10 + (e - 1) / 40), ((e - 1) % 40) / 4)));
        end
        check("fill_accepted", 32'(idx), 32'd6);
        tick();
        check("b2b_busy_end", 32'(busy4), 32'd0);
        check("b2b_tx_end", 32'(tx4), 32'd1);

        // Reset mid-frame during data bit 3 of 0xFF with 0x00 queued
        bus4.in_data  = 8'hFF;
        bus4.in_valid = 1'b1;
        tick();
        bus4.in_data  = 8'h00;
        tick();
        bus4.in_valid = 1'b0;
        repeat (17) tick();
        check("mid_count_pre", 32'(cnt4), 32'd1);
        check("mid_busy_pre", 32'(busy4), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx", 32'(tx4), 32'd1);
        check("mid_rst_count", 32'(cnt4), 32'd0);
        check("mid_rst_busy", 32'(busy4), 32'd0);
        check("mid_rst_ready", 32'(bus4.in_ready), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            check("post_rst_tx", 32'(tx4), 32'd1);
            check("post_rst_busy", 32'(busy4), 32'd0);
        end

        // Stalled producer: full FIFO, 0x3C held until space appears
        exp_q.delete();
        fork
            begin
                for (int k = 0; k < 5; k++) push_byte(8'($urandom), 10);
                check("stall_count", 32'(cnt4), 32'd4);
                check("stall_ready", 32'(bus4.in_ready), 32'd0);
                push_byte(8'h3C, 200);
                check("stall_count_after", 32'(cnt4), 32'd4);
            end
            begin
                for (int k = 0; k < 6; k++) rx_byte(400);
            end
        join
        check("stall_queue_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 60; i++) begin
            tick();
            check("stall_idle_tx", 32'(tx4), 32'd1);
        end
        check("stall_busy_end", 32'(busy4), 32'd0);

        // Random byte stream with random gaps
        fork
            begin
                for (int k = 0; k < 12; k++) begin
                    repeat ($urandom_range(0, 50)) tick();
                    r = 8'($urandom);
                    push_byte(r, 300);
                end
            end
            begin
                for (int k = 0; k < 12; k++) rx_byte(2000);
            end
        join
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (10) tick();
        check("rand_busy_end", 32'(busy4), 32'd0);

        // Divisor boundary: CLKS_PER_BIT=2, byte 0x01
        check("d2_idle_tx", 32'(tx2), 32'd1);
        bus2.in_data  = 8'h01;
        bus2.in_valid = 1'b1;
        tick();
        bus2.in_valid = 1'b0;
        check("d2_count", 32'(cnt2), 32'd1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("d2_tx", 32'(tx2), 32'(frame_bit(8'h01, i / 2)));
            check("d2_busy", 32'(busy2), 32'd1);
        end
        tick();
        check("d2_busy_end", 32'(busy2), 32'd0);
        check("d2_tx_end", 32'(tx2), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Serial transmitter that drives the NPC console output line. It accepts bytes from the core on a valid/ready interface and buffers them in a small FIFO. Each byte is sent as an 8N1 frame (start bit, 8 data bits LSB first, stop bit) at a fixed clock divisor. It sits between the core's character-output port and the top-level `tx` pin; the simulation console receiver decodes that pin.

## Interface

- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal values are 2 and above.
- `FIFO_DEPTH`, default 4: number of FIFO entries; must be a power of 2, at least 2.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `in_valid` input, 1 bit: `in_data` holds a byte to send.
- `in_ready` output, 1 bit: FIFO can accept a byte this cycle.
- `in_data` input, 8 bits: byte to transmit.
- `tx` output, 1 bit: serial line; idles high.
- `busy` output, 1 bit: a frame is in progress or the FIFO is non-empty.
- `fifo_count` output, $clog2(FIFO_DEPTH)+1 bits: number of occupied FIFO entries.

## Operation

- **Push:** a byte is pushed on a rising edge when `in_valid && in_ready`.
- **`in_ready`:** equals `fifo_count != FIFO_DEPTH` and is combinational from the count register. A full FIFO refuses a push even in a cycle where it pops.
- **Simultaneous push and pop:** `fifo_count` is unchanged; pointers wrap modulo FIFO_DEPTH.
- **FSM states:**
  - IDLE: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx` = current bit of the shift register.
  - STOP: `tx`=1.
- **Counters:**
  - Bit-timer counts 0..CLKS_PER_BIT-1.
  - Bit index counts 0..7.
- **IDLE to START:** in IDLE with `fifo_count` > 0, the head byte is popped into the shift register on the next edge and the state moves to START.
- **START to DATA:** after CLKS_PER_BIT cycles.
- **DATA:** each bit lasts CLKS_PER_BIT cycles and is sent LSB first. After bit 7 completes, the state moves to STOP.
- **End of STOP (CLKS_PER_BIT cycles):**
  - If the FIFO is non-empty, pop and go directly to START, so back-to-back frames have no idle gap.
  - Otherwise go to IDLE.
- **`tx` driving:** `tx` is driven from a register, so it never glitches.
- **`busy`:** equals `(state != IDLE) || (fifo_count != 0)`.
- **Bytes arriving mid-frame:** they are only queued; the frame in flight is never modified.
- **Reset (`rst_n` low, at any time, including mid-frame):**
  - state goes to IDLE, `tx`=1 immediately, `fifo_count`=0, pointers=0, timer=0, `busy`=0, `in_ready`=1.
  - The partial frame and all queued bytes are discarded.
  - After release, nothing is sent until new bytes are pushed.

## Timing

- **Frame length:** exactly 10*CLKS_PER_BIT cycles.
- **Latency:** a byte accepted at edge k into an empty FIFO with FSM in IDLE is popped at edge k+1. `tx` falls after edge k+1 and stays low for CLKS_PER_BIT cycles.
- **Back-to-back frames:** the stop bit's last cycle is followed immediately by the next start bit.
- **`fifo_count`:** updates on the edge of the push/pop; the decrement on pop coincides with the FSM entering START.
- **`in_ready` with `in_valid` high:** `in_ready` may deassert; the producer holds `in_data`, and the transfer completes on the first edge with `in_ready`=1.

## Test plan

All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.

1. **Reset values:** assert `rst_n`=0, then release → `tx`=1, `in_ready`=1, `busy`=0, `fifo_count`=0. `tx` stays high for 100 cycles with no input.
2. **Single byte:** push 0xA5 at edge 0 → `tx` falls after edge 1. `tx` sequence is 0,1,0,1,0,0,1,0,1,1, each level lasting 4 cycles (40 cycles total). `busy` drops on the edge that ends the stop bit, and `tx` remains 1.
3. **Fill and back-pressure:** hold `in_valid` with bytes 0x10..0x15 on consecutive edges.
   - `fifo_count` reads 1,1,2,3,4; `in_ready`=0 after the 5th acceptance.
   - 0x15 is accepted on the edge after the second pop (edge 41).
   - Six contiguous frames 0x10..0x15 follow with no idle cycle between them (240 cycles).
4. **Reset mid-frame:** push 0xFF and 0x00, then pull `rst_n` low during data bit 3 → `tx`=1 asynchronously and `fifo_count`=0. After release with no pushes, `tx` stays 1 and `busy`=0.
5. **Stalled producer:** with the FIFO full, hold `in_valid`=1 with `in_data`=0x3C → no push while `in_ready`=0. Exactly one 0x3C frame is transmitted after the queue drains, and no byte is duplicated or lost.
6. **Divisor boundary:** instantiate with CLKS_PER_BIT=2 and push 0x01 → `tx` is 0,0,1,1 followed by 14 zeros and then 1,1. The frame is 20 cycles.
